// File: rtl/sobol_rng_pkg.sv
// Shared types for the Sobol sequence generator: per-cycle step classification.
package sobol_rng_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_ADVANCE = 2'd1,
    STEP_WRAP    = 2'd2,
    STEP_CLEAR   = 2'd3
  } stepKind_e;

  // Clear outranks enable; the wrap case only matters when actually advancing.
  function automatic stepKind_e decodeStep(input logic en, input logic clr, input logic allOnes);
    if (clr) begin
      return STEP_CLEAR;
    end
    if (!en) begin
      return STEP_HOLD;
    end
    if (allOnes) begin
      return STEP_WRAP;
    end
    return STEP_ADVANCE;
  endfunction

endpackage

// File: rtl/sobol_rng_lsz.sv
// Least-significant-zero detector: one-hot position of the lowest 0 bit of cnt,
// plus a flag for the all-ones case where no such bit exists.
module sobol_lsz #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] lszOneHot,
  output logic             allOnes
);

  logic [WIDTH-1:0] cntPlusOne;

  // Adding one flips exactly the trailing ones and the lowest zero, so masking
  // with ~cnt isolates that zero; all-ones overflows to zero and yields no bit.
  always_comb begin
    cntPlusOne = cnt + WIDTH'(1);
    lszOneHot  = ~cnt & cntPlusOne;
    allOnes    = &cnt;
  end

endmodule

// File: rtl/sobol_rng.sv
// First-dimension Sobol low-discrepancy sequence generator; one new point per
// enabled cycle, registered output, wraps to 0 after 2^BITWIDTH points.
module sobol_rng
  import sobol_rng_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  output logic [BITWIDTH-1:0] sobolseq
);

  logic [BITWIDTH-1:0] cnt;
  logic [BITWIDTH-1:0] cntNext;
  logic [BITWIDTH-1:0] seqNext;
  logic [BITWIDTH-1:0] lszOneHot;
  logic [BITWIDTH-1:0] dirVec;
  logic                allOnes;
  stepKind_e           step;

  sobol_lsz #(
    .WIDTH(BITWIDTH)
  ) uLsz (
    .cnt      (cnt),
    .lszOneHot(lszOneHot),
    .allOnes  (allOnes)
  );

  // Direction vector v[k] = 1 << (BITWIDTH-1-k) is the bit-reversed one-hot.
  for (genvar k = 0; k < BITWIDTH; k++) begin : gDirVec
    assign dirVec[BITWIDTH-1-k] = lszOneHot[k];
  end

  always_comb begin
    step    = decodeStep(iEn, iClr, allOnes);
    cntNext = cnt;
    seqNext = sobolseq;
    case (step)
      STEP_CLEAR, STEP_WRAP: begin
        cntNext = '0;
        seqNext = '0;
      end
      STEP_ADVANCE: begin
        cntNext = cnt + BITWIDTH'(1);
        seqNext = sobolseq ^ dirVec;
      end
      default: begin
        cntNext = cnt;
        seqNext = sobolseq;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt      <= '0;
      sobolseq <= '0;
    end else begin
      cnt      <= cntNext;
      sobolseq <= seqNext;
    end
  end

endmodule

// File: tb/tb_sobol_rng.sv
// Scoreboard bench for sobol_rng: expected points come from the closed-form
// bit-reversed Gray-code formula of the point index.
module tb_sobol_rng;

  logic       clk  = 1'b1;
  logic       rstN = 1'b1;
  logic       en   = 1'b0;
  logic       clr  = 1'b0;
  logic       en4  = 1'b0;
  logic       clr4 = 1'b0;
  logic [7:0] seq8;
  logic [3:0] seq4;

  int compared   = 0;
  int mismatched = 0;
  int modelIdx   = 0;
  int expQ[$];

  sobol_rng #(.BITWIDTH(8)) dut (
    .iClk    (clk),
    .iRstN   (rstN),
    .iEn     (en),
    .iClr    (clr),
    .sobolseq(seq8)
  );

  sobol_rng #(.BITWIDTH(4)) dut4 (
    .iClk    (clk),
    .iRstN   (rstN),
    .iEn     (en4),
    .iClr    (clr4),
    .sobolseq(seq4)
  );

  always #5 clk = ~clk;

  function automatic int sobolRef(input int n, input int w);
    int g;
    int r;
    g = n ^ (n >> 1);
    r = 0;
    for (int i = 0; i < w; i++) begin
      if (((g >> i) & 1) != 0) r = r | (1 << (w - 1 - i));
    end
    return r;
  endfunction

  // Drive one cycle of stimulus from a negedge, queue the expected point, and
  // return at the next negedge where the bench samples the DUT.
  task automatic applyStimulus(input logic e, input logic c);
    en  = e;
    clr = c;
    if (c) modelIdx = 0;
    else if (e) modelIdx = (modelIdx + 1) % 256;
    expQ.push_back(sobolRef(modelIdx, 8));
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    #2;
    compared++;
    if (seq8 !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_during8: got %0d expected 0", seq8);
    end
    compared++;
    if (seq4 !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_during4: got %0d expected 0", seq4);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    modelIdx = 0;
    compared++;
    if (seq8 !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got %0d expected 0", seq8);
    end
  endtask

  task automatic test_first_points();
    int exp;
    int ref8[8] = '{128, 192, 64, 96, 224, 160, 32, 48};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp) || seq8 !== 8'(ref8[i])) begin
        mismatched++;
        $display("[TB] FAIL first_points[%0d]: got %0d expected %0d", i, seq8, ref8[i]);
      end
    end
  endtask

  task automatic test_full_period();
    int exp;
    int hits[256];
    int bad;
    int zeros;
    for (int v = 0; v < 256; v++) hits[v] = 0;
    zeros = 0;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'b1, 1'b0);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp)) begin
        mismatched++;
        $display("[TB] FAIL full_period[%0d]: got %0d expected %0d", i, seq8, exp);
      end
      if (i < 256) hits[int'(seq8)]++;
      if (seq8 == 8'd0) zeros++;
    end
    bad = 0;
    for (int v = 0; v < 256; v++) if (hits[v] != 1) bad++;
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL period_unique: %0d values not seen exactly once, expected 0", bad);
    end
    compared++;
    if (zeros !== 1) begin
      mismatched++;
      $display("[TB] FAIL period_wrap: zero seen %0d times, expected 1", zeros);
    end
  endtask

  task automatic test_enable_hold();
    int exp;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i >= 5, 1'b0);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp)) begin
        mismatched++;
        $display("[TB] FAIL enable_hold[%0d]: got %0d expected %0d", i, seq8, exp);
      end
    end
  endtask

  task automatic test_clear();
    int exp;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp) || seq8 !== 8'd0) begin
        mismatched++;
        $display("[TB] FAIL clear_hold[%0d]: got %0d expected 0", i, seq8);
      end
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp)) begin
        mismatched++;
        $display("[TB] FAIL clear_release[%0d]: got %0d expected %0d", i, seq8, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    int exp;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp)) begin
        mismatched++;
        $display("[TB] FAIL pre_reset[%0d]: got %0d expected %0d", i, seq8, exp);
      end
    end
    #2 rstN = 1'b0;
    #1;
    compared++;
    if (seq8 !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %0d expected 0", seq8);
    end
    @(negedge clk);
    rstN = 1'b1;
    modelIdx = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      exp = expQ.pop_front();
      compared++;
      if (seq8 !== 8'(exp)) begin
        mismatched++;
        $display("[TB] FAIL post_reset[%0d]: got %0d expected %0d", i, seq8, exp);
      end
    end
  endtask

  task automatic test_param_sweep();
    int exp;
    int exp4Q[$];
    int ref4[17] = '{8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1, 0, 8};
    en  = 1'b0;
    clr = 1'b0;
    compared++;
    if (seq4 !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL sweep_start: got %0d expected 0", seq4);
    end
    for (int i = 0; i < 17; i++) begin
      en4 = 1'b1;
      exp4Q.push_back(ref4[i]);
      @(negedge clk);
      exp = exp4Q.pop_front();
      compared++;
      if (seq4 !== 4'(exp)) begin
        mismatched++;
        $display("[TB] FAIL sweep4[%0d]: got %0d expected %0d", i, seq4, exp);
      end
    end
    en4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_points();
    test_full_period();
    test_enable_hold();
    test_clear();
    test_async_reset();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
